comparator_rr_scheduler: RTL

Shares one Comparator_32_Bit instance between NUM_REQ requesters. Uses round-robin arbitration, a valid/ready handshake on each request port, and a single registered response channel tagged with the requester ID. Sits between the ALU-side clients and the comparator datapath; it owns the comparator's Enable_In.

---
 rtl/cmp_sched_pkg.sv | 20 ++
 rtl/Comparator_32_Bit.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/comparator_rr_scheduler.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cmp_sched_pkg.sv
// Shared types and constants for the comparator round-robin scheduler.
package cmp_sched_pkg;

  localparam int DATA_W   = 32;
  localparam int MAX_ID_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    RESPOND
  } state_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic                gt;
    logic                eq;
    logic                lt;
  } rsp_t;

endpackage

// File: rtl/Comparator_32_Bit.sv
// Unsigned 32-bit magnitude comparator; outputs float when not enabled.
module Comparator_32_Bit
  import cmp_sched_pkg::*;
(
  input  logic              Enable_In,
  input  logic [DATA_W-1:0] A_In,
  input  logic [DATA_W-1:0] B_In,
  output logic              A_gt_B_Out,
  output logic              A_eq_B_Out,
  output logic              A_lt_B_Out
);

  assign A_gt_B_Out = Enable_In ? (A_In > B_In)  : 1'bz;
  assign A_eq_B_Out = Enable_In ? (A_In == B_In) : 1'bz;
  assign A_lt_B_Out = Enable_In ? (A_In < B_In)  : 1'bz;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 upward, wrapping.
module rr_arbiter
  import cmp_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int               cand_i;
  logic [ID_W-1:0]  cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_i    = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_i = (int'(last_grant) + k) % NUM_REQ;
      cand   = ID_W'(cand_i);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/comparator_rr_scheduler.sv
// Shares one Comparator_32_Bit among NUM_REQ requesters with round-robin grants.
// Optional CMP_SCHED_SIGNED_EN adds per-request two's-complement compares.
module comparator_rr_scheduler
  import cmp_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      Clock_In,
  input  logic                      Reset_In,
  input  logic [NUM_REQ-1:0]        Req_Valid_In,
  output logic [NUM_REQ-1:0]        Req_Ready_Out,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data_A_In,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data_B_In,
`ifdef CMP_SCHED_SIGNED_EN
  input  logic [NUM_REQ-1:0]        Req_Signed_In,
`endif
  output logic                      Rsp_Valid_Out,
  input  logic                      Rsp_Ready_In,
  output logic [ID_W-1:0]           Rsp_Id_Out,
  output logic                      Rsp_A_gt_B_Out,
  output logic                      Rsp_A_eq_B_Out,
  output logic                      Rsp_A_lt_B_Out,
  output logic                      Busy_Out
);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, id_q;
  logic [DATA_W-1:0]   a_q, b_q, cmp_a, cmp_b;
  rsp_t                rsp_q;
  logic                cmp_en, cmp_gt, cmp_eq, cmp_lt;
  logic                grant_fire, rsp_fire;
  logic [NUM_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic [DATA_W-1:0]   a_arr [NUM_REQ];
  logic [DATA_W-1:0]   b_arr [NUM_REQ];
  logic                unused_id_bits;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = Req_Data_A_In[DATA_W*g +: DATA_W];
    assign b_arr[g] = Req_Data_B_In[DATA_W*g +: DATA_W];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (Req_Valid_In),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_any  (arb_any)
  );

  // Flipping the sign bit maps two's-complement order onto unsigned order.
`ifdef CMP_SCHED_SIGNED_EN
  logic sgn_q;
  assign cmp_a = {a_q[DATA_W-1] ^ sgn_q, a_q[DATA_W-2:0]};
  assign cmp_b = {b_q[DATA_W-1] ^ sgn_q, b_q[DATA_W-2:0]};
`else
  assign cmp_a = a_q;
  assign cmp_b = b_q;
`endif

  Comparator_32_Bit u_cmp (
    .Enable_In  (cmp_en),
    .A_In       (cmp_a),
    .B_In       (cmp_b),
    .A_gt_B_Out (cmp_gt),
    .A_eq_B_Out (cmp_eq),
    .A_lt_B_Out (cmp_lt)
  );

  always_comb begin
    state_d       = state_q;
    Req_Ready_Out = '0;
    cmp_en        = 1'b0;
    grant_fire    = 1'b0;
    rsp_fire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any && !Reset_In) begin
          Req_Ready_Out = arb_grant;
          grant_fire    = 1'b1;
          state_d       = COMPARE;
        end
      end
      COMPARE: begin
        cmp_en  = 1'b1;
        state_d = RESPOND;
      end
      RESPOND: begin
        if (Rsp_Ready_In) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_q        <= '0;
`ifdef CMP_SCHED_SIGNED_EN
      sgn_q        <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (grant_fire) begin
        a_q          <= a_arr[arb_idx];
        b_q          <= b_arr[arb_idx];
        id_q         <= arb_idx;
        last_grant_q <= arb_idx;
`ifdef CMP_SCHED_SIGNED_EN
        sgn_q        <= Req_Signed_In[arb_idx];
`endif
      end
      // Response register is zero outside RESPOND so flags read 0 when not valid.
      if (state_q == COMPARE) begin
        rsp_q <= '{id: MAX_ID_W'(id_q), gt: cmp_gt, eq: cmp_eq, lt: cmp_lt};
      end else if (rsp_fire) begin
        rsp_q <= '0;
      end
    end
  end

  assign Rsp_Valid_Out  = (state_q == RESPOND);
  assign Busy_Out       = (state_q != IDLE);
  assign Rsp_Id_Out     = rsp_q.id[ID_W-1:0];
  assign Rsp_A_gt_B_Out = rsp_q.gt;
  assign Rsp_A_eq_B_Out = rsp_q.eq;
  assign Rsp_A_lt_B_Out = rsp_q.lt;
  assign unused_id_bits = ^rsp_q.id;

endmodule
